// File: rtl/pipeline_sequencer_if.sv
// Bundle between the pipeline sequencer and its neighbours: hazard unit, E-stage redirect,
// memory fill handshake, pipeline-register controls and performance counters.
interface pipeline_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             HazStall;
    logic             PCSrcE;
    logic             MissM;
    logic             MemReadyM;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             FreezeEMW;
    logic             FillReq;
    logic             TimeoutErr;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output HazStall, PCSrcE, MissM, MemReadyM,
        input  StallF, StallD, FlushD, FlushE, FreezeEMW, FillReq, TimeoutErr,
        input  StallCount, FlushCount
    );

    modport slave (
        input  HazStall, PCSrcE, MissM, MemReadyM,
        output StallF, StallD, FlushD, FlushE, FreezeEMW, FillReq, TimeoutErr,
        output StallCount, FlushCount
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Prioritised stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect and
// data-memory miss fill with timeout detection and saturating stall/flush counters.
module pipeline_sequencer #(
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_sequencer_if.slave bus
);
    localparam int TW = $clog2(MISS_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(MISS_TIMEOUT);

    typedef enum logic [1:0] {RUN, FILL, DRAIN} state_e;

    state_e           state_q, state_d;
    logic             fill_req_q, fill_req_d;
    logic             err_q, err_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hold_f, hold_dec, clr_dec, clr_exe, freeze;

    always_comb begin
        state_d  = state_q;
        hold_f   = 1'b0;
        hold_dec = 1'b0;
        clr_dec  = 1'b0;
        clr_exe  = 1'b0;
        freeze   = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.MissM) begin
                    hold_f   = 1'b1;
                    hold_dec = 1'b1;
                    freeze   = 1'b1;
                    state_d  = FILL;
                end else if (bus.PCSrcE) begin
                    clr_dec = 1'b1;
                    clr_exe = 1'b1;
                end else if (bus.HazStall) begin
                    hold_f   = 1'b1;
                    hold_dec = 1'b1;
                    clr_exe  = 1'b1;
                end
            end
            FILL: begin
                hold_f   = 1'b1;
                hold_dec = 1'b1;
                freeze   = 1'b1;
                if (bus.MemReadyM) state_d = DRAIN;
            end
            DRAIN: begin
                hold_f   = 1'b1;
                hold_dec = 1'b1;
                freeze   = 1'b1;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
        // Controls must be quiet while reset is held, independent of the registered state.
        if (rst) begin
            hold_f   = 1'b0;
            hold_dec = 1'b0;
            clr_dec  = 1'b0;
            clr_exe  = 1'b0;
            freeze   = 1'b0;
        end
    end

    always_comb begin
        fill_req_d = (state_d == FILL);
        tmo_d      = tmo_q;
        if (state_q == RUN && state_d == FILL) begin
            tmo_d = '0;
        end else if (state_q == FILL && tmo_q != TMO_LIMIT) begin
            tmo_d = tmo_q + TW'(1);
        end
        err_d       = err_q | ((state_q == FILL) && (tmo_d == TMO_LIMIT));
        stall_cnt_d = (hold_f && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (clr_exe && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            fill_req_q  <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_req_q  <= fill_req_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.StallF     = hold_f;
    assign bus.StallD     = hold_dec;
    assign bus.FlushD     = clr_dec;
    assign bus.FlushE     = clr_exe;
    assign bus.FreezeEMW  = freeze;
    assign bus.FillReq    = fill_req_q;
    assign bus.TimeoutErr = err_q;
    assign bus.StallCount = stall_cnt_q;
    assign bus.FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: two instances (short timeout / 3-bit counters, and defaults)
// driven by directed then random stimulus and compared each cycle to a behavioural model.
module tb_pipeline_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic haz = 1'b0, pc = 1'b0, miss = 1'b0, rdy = 1'b0;
    int   tests = 0, fails = 0;

    always #5 clk = ~clk;

    pipeline_sequencer_if #(.CNT_W(3))  b0 ();
    pipeline_sequencer_if #(.CNT_W(32)) b1 ();

    assign b0.HazStall = haz;  assign b1.HazStall = haz;
    assign b0.PCSrcE   = pc;   assign b1.PCSrcE   = pc;
    assign b0.MissM    = miss; assign b1.MissM    = miss;
    assign b0.MemReadyM = rdy; assign b1.MemReadyM = rdy;

    pipeline_sequencer #(.MISS_TIMEOUT(4), .CNT_W(3)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    pipeline_sequencer #(.MISS_TIMEOUT(64), .CNT_W(32)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string nm, input int inst, input longint unsigned act,
                       input longint unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    // Behavioural model: a miss occupies the pipeline until the fill returns plus one capture
    // cycle; counters are plain saturating tallies.
    bit              in_fill[2], in_drain[2], m_err[2];
    int unsigned     fill_age[2];
    longint unsigned m_sc[2], m_fc[2];
    longint unsigned cmax[2] = '{64'd7, 64'hFFFF_FFFF};
    int unsigned     tmo[2]  = '{4, 64};
    bit              e_sf[2], e_sd[2], e_fd[2], e_fe[2], e_frz[2];

    always begin
        @(negedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            bit busy;
            if (rst) begin
                in_fill[i] = 0; in_drain[i] = 0; m_err[i] = 0;
                fill_age[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            end
            busy = in_fill[i] || in_drain[i];
            {e_sf[i], e_sd[i], e_fd[i], e_fe[i], e_frz[i]} = 5'b0;
            if (rst) ;
            else if (busy || miss) {e_sf[i], e_sd[i], e_frz[i]} = 3'b111;
            else if (pc)           {e_fd[i], e_fe[i]} = 2'b11;
            else if (haz)          {e_sf[i], e_sd[i], e_fe[i]} = 3'b111;
        end
        chk("StallF", 0, b0.StallF, e_sf[0]);       chk("StallF", 1, b1.StallF, e_sf[1]);
        chk("StallD", 0, b0.StallD, e_sd[0]);       chk("StallD", 1, b1.StallD, e_sd[1]);
        chk("FlushD", 0, b0.FlushD, e_fd[0]);       chk("FlushD", 1, b1.FlushD, e_fd[1]);
        chk("FlushE", 0, b0.FlushE, e_fe[0]);       chk("FlushE", 1, b1.FlushE, e_fe[1]);
        chk("FreezeEMW", 0, b0.FreezeEMW, e_frz[0]); chk("FreezeEMW", 1, b1.FreezeEMW, e_frz[1]);
        chk("FillReq", 0, b0.FillReq, in_fill[0] && !rst);
        chk("FillReq", 1, b1.FillReq, in_fill[1] && !rst);
        chk("TimeoutErr", 0, b0.TimeoutErr, m_err[0]);
        chk("TimeoutErr", 1, b1.TimeoutErr, m_err[1]);
        chk("StallCount", 0, longint'(b0.StallCount), m_sc[0]);
        chk("StallCount", 1, longint'(b1.StallCount), m_sc[1]);
        chk("FlushCount", 0, longint'(b0.FlushCount), m_fc[0]);
        chk("FlushCount", 1, longint'(b1.FlushCount), m_fc[1]);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (e_sf[i] && m_sc[i] < cmax[i]) m_sc[i]++;
                if (e_fe[i] && m_fc[i] < cmax[i]) m_fc[i]++;
                if (in_fill[i]) begin
                    fill_age[i]++;
                    if (fill_age[i] >= tmo[i]) m_err[i] = 1;
                    if (rdy) begin in_fill[i] = 0; in_drain[i] = 1; end
                end else if (in_drain[i]) begin
                    in_drain[i] = 0;
                end else if (miss) begin
                    in_fill[i] = 1; fill_age[i] = 0;
                end
            end
        end
    end

    task automatic step(input bit h, input bit p, input bit m, input bit r);
        @(negedge clk);
        haz = h; pc = p; miss = m; rdy = r;
        #3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; haz = 0; pc = 0; miss = 0; rdy = 0;
        @(negedge clk);
        rst = 1'b0;
        #3;
    endtask

    initial begin
        // Reset state, sampled while rst is still high
        @(negedge clk); #3;
        chk("rst_StallCount", 1, b1.StallCount, 0);
        chk("rst_FillReq", 1, b1.FillReq, 0);
        chk("rst_StallF", 0, b0.StallF, 0);
        do_reset();

        // Load-use, then branch alongside load-use
        step(1, 0, 0, 0);
        chk("lu_StallF", 1, b1.StallF, 1); chk("lu_FlushE", 1, b1.FlushE, 1);
        step(0, 0, 0, 0);
        chk("lu_StallCount", 1, b1.StallCount, 1); chk("lu_FlushCount", 1, b1.FlushCount, 1);
        step(1, 1, 0, 0);
        chk("br_FlushD", 1, b1.FlushD, 1); chk("br_StallF", 1, b1.StallF, 0);
        step(0, 0, 0, 0);
        chk("br_StallCount", 1, b1.StallCount, 1); chk("br_FlushCount", 1, b1.FlushCount, 2);

        // Miss with fill returning in cycle 4
        do_reset();
        step(0, 0, 1, 0);
        chk("miss_c0_StallF", 1, b1.StallF, 1); chk("miss_c0_FillReq", 1, b1.FillReq, 0);
        step(0, 0, 0, 0);
        chk("miss_c1_FillReq", 1, b1.FillReq, 1);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("miss_c4_FillReq", 1, b1.FillReq, 1);
        step(0, 0, 0, 0);
        chk("miss_c5_FillReq", 1, b1.FillReq, 0); chk("miss_c5_StallF", 1, b1.StallF, 1);
        step(0, 0, 0, 0);
        chk("miss_c6_StallF", 1, b1.StallF, 0); chk("miss_StallCount", 1, b1.StallCount, 6);

        // Miss with a held branch: flush only once released
        do_reset();
        step(0, 1, 1, 0);
        chk("mb_c0_FlushD", 1, b1.FlushD, 0);
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        chk("mb_c5_FlushD", 1, b1.FlushD, 0);
        step(0, 1, 0, 0);
        chk("mb_c6_FlushD", 1, b1.FlushD, 1); chk("mb_c6_FlushE", 1, b1.FlushE, 1);
        step(0, 0, 0, 0);

        // Timeout on the short-timeout instance; fill completes later, error stays
        do_reset();
        step(0, 0, 1, 0);
        for (int c = 1; c <= 4; c++) step(0, 0, 0, 0);
        chk("to_c4_TimeoutErr", 0, b0.TimeoutErr, 0);
        step(0, 0, 0, 0);
        chk("to_c5_TimeoutErr", 0, b0.TimeoutErr, 1); chk("to_c5_FillReq", 0, b0.FillReq, 1);
        step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 0);
        chk("to_c8_StallF", 0, b0.StallF, 0); chk("to_c8_TimeoutErr", 0, b0.TimeoutErr, 1);

        // Long fill on the default instance, then reset mid-fill
        do_reset();
        step(0, 0, 1, 0);
        for (int c = 1; c <= 64; c++) step(0, 0, 0, 0);
        chk("to64_c64_TimeoutErr", 1, b1.TimeoutErr, 0);
        step(0, 0, 0, 0);
        chk("to64_c65_TimeoutErr", 1, b1.TimeoutErr, 1);
        @(negedge clk); rst = 1'b1; #3;
        chk("rstfill_FillReq", 1, b1.FillReq, 0); chk("rstfill_StallF", 1, b1.StallF, 0);
        @(negedge clk); rst = 1'b0; #3;
        chk("rstfill_TimeoutErr", 1, b1.TimeoutErr, 0); chk("rstfill_StallF", 0, b0.StallF, 0);

        // Counter saturation: 9 stall cycles
        do_reset();
        for (int c = 0; c < 9; c++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("sat_StallCount", 0, b0.StallCount, 7); chk("sat_StallCount", 1, b1.StallCount, 9);
        chk("sat_FlushCount", 0, b0.FlushCount, 7);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
